// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit
//  Brief    : Next-PC selection, PC register and checkpointed circular
//             return-address stack for the fetch front end.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
  parameter int                PC_W        = 32,
  parameter int                FETCH_WIDTH = 4,
  parameter int                INST_BYTES  = 8,
  parameter int                RAS_DEPTH   = 16,
  parameter logic [PC_W-1:0]   RESET_PC    = '0,
  localparam int               PTR_W       = $clog2(RAS_DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall_i,
  input  logic                        icacheMiss_i,
  input  logic                        recoverFlag_i,
  input  logic [PC_W-1:0]             recoverPC_i,
  input  logic                        exceptionFlag_i,
  input  logic [PC_W-1:0]             exceptionPC_i,
  input  logic                        flagRecoverEX_i,
  input  logic [PC_W-1:0]             targetAddrEX_i,
  input  logic                        flagRecoverID_i,
  input  logic                        flagCallID_i,
  input  logic [PC_W-1:0]             callPCID_i,
  input  logic                        flagRtrID_i,
  input  logic [PC_W-1:0]             targetAddrID_i,
  input  logic [PTR_W-1:0]            rasPtrID_i,
  input  logic [FETCH_WIDTH-1:0]      btbHit_i,
  input  logic [2*FETCH_WIDTH-1:0]    btbCtrlType_i,
  input  logic [PC_W*FETCH_WIDTH-1:0] btbTarget_i,
  input  logic [FETCH_WIDTH-1:0]      prediction_i,
  output logic [PC_W-1:0]             pc_o,
  output logic                        fetchValid_o,
  output logic                        takenValid_o,
  output logic [2:0]                  takenSlot_o,
  output logic [PC_W*FETCH_WIDTH-1:0] slotTarget_o,
  output logic [PTR_W-1:0]            rasPtr_o,
  output logic [PTR_W:0]              rasCount_o
);

  // Control-type encodings carried per slot by the BTB.
  localparam logic [1:0] c_type_ret  = 2'b00;
  localparam logic [1:0] c_type_call = 2'b01;
  localparam logic [1:0] c_type_cond = 2'b11;

  // Sequential fall-through stride and RAS occupancy ceiling.
  localparam logic [PC_W-1:0] c_bundle_bytes = PC_W'(FETCH_WIDTH * INST_BYTES);
  localparam logic [PTR_W:0]  c_ras_full     = (PTR_W+1)'(RAS_DEPTH);

  // Architectural state.
  logic [PC_W-1:0]  r_pc;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_cnt;
  logic [PC_W-1:0]  r_ras [RAS_DEPTH];

  // Per-slot decode.
  logic [1:0]       w_type       [FETCH_WIDTH];
  logic [PC_W-1:0]  w_slot_target[FETCH_WIDTH];
  logic [PC_W-1:0]  w_ret_addr   [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] w_hit;

  // Selected (first taken) slot.
  logic             w_taken_valid;
  logic [2:0]       w_taken_slot;
  logic [1:0]       w_sel_type;
  logic [PC_W-1:0]  w_sel_target;
  logic [PC_W-1:0]  w_sel_ret;

  // Redirect and next-state signals.
  logic             w_fetch_valid;
  logic             w_any_redirect;
  logic             w_pc_en;
  logic [PC_W-1:0]  w_next_pc;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W:0]   w_cnt_nxt;
  logic [PTR_W:0]   w_cnt_inc;
  logic [PTR_W:0]   w_cnt_dec;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PC_W-1:0]  w_wr_data;
  logic [PTR_W-1:0] w_id_ptr_inc;
  logic [PTR_W-1:0] w_id_ptr_dec;

  assign w_fetch_valid  = ~stall_i & ~icacheMiss_i;
  assign w_any_redirect = recoverFlag_i | exceptionFlag_i | flagRecoverEX_i | flagRecoverID_i;

  // Back-end redirects beyond ID must land even while fetch is frozen.
  assign w_pc_en = recoverFlag_i | exceptionFlag_i | flagRecoverEX_i | w_fetch_valid;

  // Saturating occupancy steps; the pointer itself always wraps.
  assign w_cnt_inc = (r_cnt == c_ras_full) ? r_cnt : r_cnt + 1'b1;
  assign w_cnt_dec = (r_cnt == '0)         ? r_cnt : r_cnt - 1'b1;

  assign w_id_ptr_inc = rasPtrID_i + 1'b1;
  assign w_id_ptr_dec = rasPtrID_i - 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
      assign w_type[gi]     = btbCtrlType_i[2*gi +: 2];
      // Conditional branches need a taken prediction; other types always redirect.
      assign w_hit[gi]      = btbHit_i[gi] & (prediction_i[gi] | (w_type[gi] != c_type_cond));
      // Returns take their target from the current RAS top rather than the BTB.
      assign w_slot_target[gi] = (w_type[gi] == c_type_ret) ? r_ras[r_ptr]
                                                            : btbTarget_i[PC_W*gi +: PC_W];
      assign w_ret_addr[gi] = r_pc + PC_W'((gi + 1) * INST_BYTES);
      assign slotTarget_o[PC_W*gi +: PC_W] = w_slot_target[gi];
    end
  endgenerate

  // Priority-encode the lowest taken slot and pick its attributes.
  always_comb begin
    w_taken_valid = 1'b0;
    w_taken_slot  = 3'd0;
    w_sel_type    = 2'b00;
    w_sel_target  = '0;
    w_sel_ret     = '0;
    for (int j = FETCH_WIDTH - 1; j >= 0; j--) begin
      if (w_hit[j]) begin
        w_taken_valid = 1'b1;
        w_taken_slot  = 3'(j);
        w_sel_type    = w_type[j];
        w_sel_target  = w_slot_target[j];
        w_sel_ret     = w_ret_addr[j];
      end
    end
  end

  // Next fetch PC, highest-priority redirect first.
  always_comb begin
    if (recoverFlag_i) begin
      w_next_pc = recoverPC_i;
    end else if (exceptionFlag_i) begin
      w_next_pc = exceptionPC_i;
    end else if (flagRecoverEX_i) begin
      w_next_pc = targetAddrEX_i;
    end else if (flagRecoverID_i) begin
      w_next_pc = flagRtrID_i ? r_ras[rasPtrID_i] : targetAddrID_i;
    end else if (w_taken_valid) begin
      w_next_pc = w_sel_target;
    end else begin
      w_next_pc = r_pc + c_bundle_bytes;
    end
  end

  // Next RAS pointer, occupancy and optional entry write.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_ptr + 1'b1;
    w_wr_data = w_sel_ret;
    if (recoverFlag_i || exceptionFlag_i) begin
      // Stack is emptied logically; stale entries stay in the array.
      w_ptr_nxt = '0;
      w_cnt_nxt = '0;
    end else if (flagRecoverEX_i) begin
      // Indirect repair leaves the stack exactly as it is.
      w_ptr_nxt = r_ptr;
    end else if (flagRecoverID_i) begin
      // Restore the bundle checkpoint, then replay the missed call/return.
      w_ptr_nxt = rasPtrID_i;
      if (flagCallID_i) begin
        w_wr_en   = 1'b1;
        w_wr_idx  = w_id_ptr_inc;
        w_wr_data = callPCID_i;
        w_ptr_nxt = w_id_ptr_inc;
        w_cnt_nxt = w_cnt_inc;
      end else if (flagRtrID_i) begin
        w_ptr_nxt = w_id_ptr_dec;
        w_cnt_nxt = w_cnt_dec;
      end
    end else if (w_fetch_valid && w_taken_valid) begin
      // Speculative push/pop from the first taken slot only.
      if (w_sel_type == c_type_call) begin
        w_wr_en   = 1'b1;
        w_ptr_nxt = r_ptr + 1'b1;
        w_cnt_nxt = w_cnt_inc;
      end else if (w_sel_type == c_type_ret) begin
        w_ptr_nxt = r_ptr - 1'b1;
        w_cnt_nxt = w_cnt_dec;
      end
    end
  end

  // PC register: holds on stall/miss unless a late-stage redirect arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (w_pc_en) begin
      r_pc <= w_next_pc;
    end
  end

  // RAS pointer, occupancy and storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int e = 0; e < RAS_DEPTH; e++) begin
        r_ras[e] <= '0;
      end
    end else begin
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_wr_en) begin
        r_ras[w_wr_idx] <= w_wr_data;
      end
    end
  end

  assign pc_o         = r_pc;
  assign fetchValid_o = w_fetch_valid;
  assign takenValid_o = w_taken_valid;
  assign takenSlot_o  = w_taken_slot;
  assign rasPtr_o     = r_ptr;
  assign rasCount_o   = r_cnt;

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Parametrised next-PC generator and return-address stack (RAS) for the fetch front end.
- Each cycle it selects the next fetch PC from the redirect sources and the first predicted-taken slot of the current bundle.
- It owns the PC register and a circular RAS with per-bundle checkpoints for ID-stage repair.
- Sits between the BTB/branch predictor and the L1 I-cache, with FETCH_WIDTH slots instead of a fixed four.

Parameters:
- PC_W, 32, PC width in bits.
- FETCH_WIDTH, 4, instructions per fetch bundle (1..8).
- INST_BYTES, 8, byte stride per instruction slot.
- RAS_DEPTH, 16, RAS entries (power of 2, ≥2); PTR_W = log2(RAS_DEPTH).
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall_i  in  1  back-end stall.
- icacheMiss_i  in  1  I-cache miss for the current PC.
- recoverFlag_i  in  1  commit-time recovery.
- recoverPC_i  in  PC_W  recovery target.
- exceptionFlag_i  in  1  exception redirect.
- exceptionPC_i  in  PC_W  exception target.
- flagRecoverEX_i  in  1  EX-stage indirect mispredict.
- targetAddrEX_i  in  PC_W  EX target.
- flagRecoverID_i  in  1  ID-stage direct mispredict.
- flagCallID_i  in  1  ID-resolved call missed by BTB.
- callPCID_i  in  PC_W  return address to push.
- flagRtrID_i  in  1  ID-resolved return missed by BTB.
- targetAddrID_i  in  PC_W  ID target.
- rasPtrID_i  in  PTR_W  RAS checkpoint of the bundle being repaired.
- btbHit_i  in  FETCH_WIDTH  per-slot BTB hit.
- btbCtrlType_i  in  2*FETCH_WIDTH  per-slot type: 00 return, 01 call, 10 jump, 11 conditional.
- btbTarget_i  in  PC_W*FETCH_WIDTH  per-slot target.
- prediction_i  in  FETCH_WIDTH  per-slot direction.
- pc_o  out  PC_W  current fetch PC.
- fetchValid_o  out  1  ~stall_i & ~icacheMiss_i.
- takenValid_o  out  1  some slot predicted taken.
- takenSlot_o  out  3  lowest taken slot index, 0 when none.
- slotTarget_o  out  PC_W*FETCH_WIDTH  per-slot target; RAS top for returns.
- rasPtr_o  out  PTR_W  RAS checkpoint for this bundle.
- rasCount_o  out  PTR_W+1  RAS occupancy.

Behaviour:
- Reset, asynchronous while low: PC=RESET_PC, ptr=0, count=0, all RAS entries 0. Outputs follow combinationally from this state.
- Effective hit per slot: hit[i] = btbHit_i[i] & (prediction_i[i] | type[i]!=11). The taken slot k is the lowest i with hit set.
- Slot target: type 00 gives entry[ptr]; otherwise btbTarget_i slice i.
- nextPC priority, highest first:
  1. recoverFlag_i
  2. exceptionFlag_i
  3. flagRecoverEX_i
  4. flagRecoverID_i: entry[rasPtrID_i] if flagRtrID_i, else targetAddrID_i
  5. slot k target
  6. PC + FETCH_WIDTH*INST_BYTES, mod 2^PC_W
- PC register update at posedge:
  - recoverFlag_i, exceptionFlag_i and flagRecoverEX_i update PC regardless of stall or miss.
  - Otherwise PC updates only when fetchValid_o; it holds on stall or miss.
- RAS on recoverFlag_i or exceptionFlag_i: ptr and count go to 0; entries are retained. No push or pop.
- RAS on flagRecoverEX_i: ptr and count unchanged.
- RAS on flagRecoverID_i (no higher source active), taking effect even when stalled:
  - ptr <= rasPtrID_i.
  - If flagCallID_i: write callPCID_i at rasPtrID_i+1 and set ptr to rasPtrID_i+1.
  - Else if flagRtrID_i: set ptr to rasPtrID_i-1.
  - Count moves +1/-1 correspondingly, saturating.
- Speculative RAS activity, only when fetchValid_o and no redirect is active:
  - Slot k call: push PC+(k+1)*INST_BYTES at ptr+1 and ptr++.
  - Slot k return: ptr--.
  - At most one push or pop per cycle.
- Pointer arithmetic is mod RAS_DEPTH.
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop when empty still returns entry[ptr] and decrements ptr; count stays 0.
- Latency: nextPC is combinational; the PC register introduces one cycle.
- Simultaneous redirects: only the highest-priority source acts on PC and RAS.

Test Plan (FETCH_WIDTH=4, INST_BYTES=8, RAS_DEPTH=4):
- Reset low then high: pc_o=0, rasCount_o=0. With no hits, PC steps 0→0x20→0x40.
- PC=0x100, slot2 conditional, predicted taken, target 0x500; slot1 jump with btbHit=0 → next PC=0x500, takenSlot_o=2.
- PC=0x100, slot1 call to 0x800 → PC=0x800, entry[1]=0x110, count=1. Then slot0 return → PC=0x110, ptr=0, count=0.
- 5 consecutive pushes → count saturates at 4 and ptr wraps to 1. Then 5 pops → count stays 0 after the fourth pop, with no X values.
- stall_i=1 with flagRecoverEX_i=1, target 0x900 → PC=0x900 and RAS unchanged. stall_i=1 with icacheMiss_i=1 and no redirect → PC holds.
- Same cycle: recoverFlag_i (0xA00), flagRecoverID_i and a call in slot0 → PC=0xA00, ptr=0, count=0, no push.
- flagRecoverID_i + flagRtrID_i with rasPtrID_i=2 and entry[2]=0x340 → PC=0x340, ptr=1. Assert reset mid-sequence → immediate return to the reset state.
